// File: rtl/fifo_ctrl_8byte_pkg.sv
// Shared parameters and FSM encoding for the 8-byte FIFO controller.
package fifo_ctrl_8byte_pkg;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 2 ** AW;

  // state    | meaning
  // ST_IDLE  | port free; a fetch may be issued if memory holds data
  // ST_FETCH | read in flight; mem_rdata is captured at the end of this cycle
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_ctrl_8byte_ptr_cnt.sv
// Read/write pointers and memory occupancy for the FIFO controller.
module fifo_ctrl_8byte_ptr_cnt
  import fifo_ctrl_8byte_pkg::*;
#(
  parameter int P_AW = AW
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_wr_en,
  input  logic            i_rd_en,
  output logic [P_AW-1:0] o_wr_ptr,
  output logic [P_AW-1:0] o_rd_ptr,
  output logic [P_AW:0]   o_mem_cnt,
  output logic            o_full,
  output logic            o_empty
);

  localparam logic [P_AW-1:0] PTR_ONE = 1;
  localparam logic [P_AW:0]   CNT_ONE = 1;
  localparam logic [P_AW:0]   CNT_MAX = {1'b1, {P_AW{1'b0}}};

  logic [P_AW-1:0] r_wr_ptr;
  logic [P_AW-1:0] r_rd_ptr;
  logic [P_AW:0]   r_mem_cnt;

  // Pointers wrap naturally at 2**P_AW; count tracks words held in memory.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_mem_cnt <= '0;
    end else begin
      if (i_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({i_wr_en, i_rd_en})
        2'b10:   r_mem_cnt <= r_mem_cnt + CNT_ONE;
        2'b01:   r_mem_cnt <= r_mem_cnt - CNT_ONE;
        default: r_mem_cnt <= r_mem_cnt;
      endcase
    end
  end

  assign o_wr_ptr  = r_wr_ptr;
  assign o_rd_ptr  = r_rd_ptr;
  assign o_mem_cnt = r_mem_cnt;
  assign o_full    = (r_mem_cnt == CNT_MAX);
  assign o_empty   = (r_mem_cnt == '0);

endmodule

// File: rtl/fifo_ctrl_8byte.sv
// FIFO controller in front of a single-port 8-byte memory with a
// prefetched, registered head-of-queue output.
module fifo_ctrl_8byte
  import fifo_ctrl_8byte_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push_valid,
  output logic          o_push_ready,
  input  logic [DW-1:0] i_push_data,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [DW-1:0] o_out_data,
  output logic [AW:0]   o_level,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_mem_wr_bar,
  output logic          o_mem_rd_bar,
  output logic          o_mem_en,
  input  logic [DW-1:0] i_mem_rdata
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_out_valid;
  logic [DW-1:0]   r_out_data;
  logic            w_fetch_go;
  logic            w_push_ready;
  logic            w_wr;
  logic [AW-1:0]   w_wr_ptr;
  logic [AW-1:0]   w_rd_ptr;
  logic [AW:0]     w_mem_cnt;
  logic            w_full;
  logic            w_empty;

  fifo_ctrl_8byte_ptr_cnt #(.P_AW(AW)) u_ptr_cnt (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (w_wr),
    .i_rd_en   (w_fetch_go),
    .o_wr_ptr  (w_wr_ptr),
    .o_rd_ptr  (w_rd_ptr),
    .o_mem_cnt (w_mem_cnt),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state, port arbitration (fetch beats write) and memory strobes.
  // Gating with i_rst_n keeps the port quiet and push_ready low while held.
  always_comb begin
    w_state_nxt  = r_state;
    w_fetch_go   = 1'b0;
    o_mem_en     = 1'b0;
    o_mem_wr_bar = 1'b1;
    o_mem_rd_bar = 1'b1;
    o_mem_addr   = w_rd_ptr;
    o_mem_wdata  = i_push_data;
    case (r_state)
      ST_IDLE: begin
        w_fetch_go = i_rst_n & !w_empty & (!r_out_valid | i_out_ready);
        if (w_fetch_go) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    w_push_ready = i_rst_n & !w_full & !w_fetch_go;
    w_wr         = i_push_valid & w_push_ready;
    if (w_fetch_go) begin
      o_mem_en     = 1'b1;
      o_mem_rd_bar = 1'b0;
    end else if (w_wr) begin
      o_mem_en     = 1'b1;
      o_mem_wr_bar = 1'b0;
      o_mem_addr   = w_wr_ptr;
    end
  end

  // Output register: a load from memory wins over a same-cycle consume.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (r_state == ST_FETCH) begin
      r_out_valid <= 1'b1;
      r_out_data  <= i_mem_rdata;
    end else if (r_out_valid && i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_push_ready = w_push_ready;
  assign o_out_valid  = r_out_valid;
  assign o_out_data   = r_out_data;
  assign o_level      = w_mem_cnt
                      + {{AW{1'b0}}, (r_state == ST_FETCH)}
                      + {{AW{1'b0}}, r_out_valid};

endmodule

// File: tb/tb_fifo_ctrl_8byte.sv
// Bench: controller plus behavioural 8-byte memory, checked against a queue.
module tb_fifo_ctrl_8byte;

  logic       clk;
  logic       rst_n;
  logic       push_valid;
  logic       push_ready;
  logic [7:0] push_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] level;
  logic [2:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_wr_bar;
  logic       mem_rd_bar;
  logic       mem_en;
  logic [7:0] mem_rdata;

  logic [7:0] mem_arr [8];

  int n_cmp  = 0;
  int n_fail = 0;
  int n_pop  = 0;
  logic [7:0] sb_q [$];

  fifo_ctrl_8byte dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_push_valid (push_valid),
    .o_push_ready (push_ready),
    .i_push_data  (push_data),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_data   (out_data),
    .o_level      (level),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_wr_bar (mem_wr_bar),
    .o_mem_rd_bar (mem_rd_bar),
    .o_mem_en     (mem_en),
    .i_mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read, write on strobe; contents survive reset.
  initial mem_rdata = 8'h00;
  always @(posedge clk) begin
    if (mem_en && !mem_wr_bar) mem_arr[mem_addr] <= mem_wdata;
    if (mem_en && !mem_rd_bar) mem_rdata <= mem_arr[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard sampled mid-cycle: handshakes seen here complete on the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      chk("level_vs_model", 32'(level), 32'(sb_q.size()));
      chk("strobes_exclusive", 32'(!mem_wr_bar && !mem_rd_bar), 32'd0);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("pop_unexpected", 32'(out_data), 32'hffff_ffff);
        end else begin
          chk("pop_data", 32'(out_data), 32'(sb_q.pop_front()));
        end
        n_pop++;
      end
      if (push_valid && push_ready) sb_q.push_back(push_data);
    end
  end

  // Holds push_valid until accepted; returns #1 after the accepting edge.
  task automatic push_byte(input logic [7:0] d);
    logic acc;
    acc = 1'b0;
    push_valid = 1'b1;
    push_data  = d;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      if (push_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    push_valid = 1'b0;
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain_until_empty();
    logic done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (level == 4'd0 && !out_valid) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic       pv;
    logic [7:0] pd;
    logic       ordy;
    logic       e_prdy;
    logic       e_en;
    logic       e_wrb;
    logic       e_rdb;
    logic [2:0] e_addr;
    logic [3:0] e_lvl;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pop0;
    // single entry, then contention between a fetch and a pending push
    vecs[0]  = '{1'b1, 8'haa, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 4'd0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'd1};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 4'd1};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 4'd1};
    vecs[4]  = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 4'd0};
    vecs[5]  = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 4'd1};
    vecs[6]  = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 4'd1};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 4'd2};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 4'd1};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 4'd1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 4'd0};

    rst_n      = 1'b0;
    push_valid = 1'b1;
    push_data  = 8'h77;
    out_ready  = 1'b0;

    // reset held for two cycles, with a push offered to prove it is ignored
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_wr_bar", 32'(mem_wr_bar), 32'd1);
    chk("rst_rd_bar", 32'(mem_rd_bar), 32'd1);
    chk("rst_push_ready", 32'(push_ready), 32'd0);
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_push_ready", 32'(push_ready), 32'd1);
    @(posedge clk);
    #1;

    // vector table
    for (int i = 0; i < 11; i++) begin
      push_valid = vecs[i].pv;
      push_data  = vecs[i].pd;
      out_ready  = vecs[i].ordy;
      @(negedge clk);
      chk($sformatf("v%0d_push_ready", i), 32'(push_ready), 32'(vecs[i].e_prdy));
      chk($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].e_en));
      chk($sformatf("v%0d_wr_bar", i), 32'(mem_wr_bar), 32'(vecs[i].e_wrb));
      chk($sformatf("v%0d_rd_bar", i), 32'(mem_rd_bar), 32'(vecs[i].e_rdb));
      chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].e_lvl));
      if (vecs[i].e_en && !vecs[i].e_wrb)
        chk($sformatf("v%0d_wdata", i), 32'(mem_wdata), 32'(vecs[i].pd));
      @(posedge clk);
      #1;
    end
    push_valid = 1'b0;

    // fill to 9 with the consumer stalled
    out_ready = 1'b0;
    for (int d = 8'h11; d <= 8'h19; d++) push_byte(8'(d));
    push_valid = 1'b1;
    push_data  = 8'h1a;
    @(negedge clk);
    chk("full_level", 32'(level), 32'd9);
    chk("full_push_ready", 32'(push_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_head", 32'(out_data), 32'h11);
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    drain_until_empty();

    // 20 entries through with the consumer always ready; pointers wrap
    pop0 = n_pop;
    out_ready = 1'b1;
    for (int d = 8'h20; d <= 8'h33; d++) push_byte(8'(d));
    drain_until_empty();
    chk("wrap_pop_count", 32'(n_pop - pop0), 32'd20);

    // reset while a fetch of 8'h5c is in flight
    out_ready = 1'b1;
    push_byte(8'h5c);
    @(negedge clk);
    chk("mf_fetch_rd_bar", 32'(mem_rd_bar), 32'd0);
    @(posedge clk);
    #1;
    chk("mf_rdata_present", 32'(mem_rdata), 32'h5c);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mf_out_valid", 32'(out_valid), 32'd0);
    chk("mf_level", 32'(level), 32'd0);
    chk("mf_mem_en", 32'(mem_en), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mf_post_out_valid%0d", k), 32'(out_valid), 32'd0);
      chk($sformatf("mf_post_level%0d", k), 32'(level), 32'd0);
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
